register_file: RTL and testbench

- General-purpose register file for the single-cycle RISC datapath: 32 registers of 32 bits each.
- Two asynchronous (combinational) read ports feed the ALU operands.
- One synchronous write port, clocked on the rising edge, is driven by the writeback stage.
- Register 0 is hardwired to zero.

---
 rtl/register_file.sv | 56 +++++
 tb/tb_register_file.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/register_file.sv
// register_file: 32 x 32-bit general-purpose register file for the
// single-cycle RISC datapath. Two combinational read ports feed the ALU.
// One synchronous write port is driven by writeback. Register 0 always
// reads as zero. The active-low reset clears every register at once.
module register_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_REGS   = 2 ** ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] reg1,
    input  logic [ADDR_WIDTH-1:0] reg2,
    input  logic [ADDR_WIDTH-1:0] write_reg,
    input  logic                  regWrite,
    input  logic [DATA_WIDTH-1:0] writeData,
    output logic [DATA_WIDTH-1:0] data1,
    output logic [DATA_WIDTH-1:0] data2
);

    // Register storage and its next-state image.
    // Entry 0 exists only so that every address indexes the array.
    // It is held at zero by both the reset and the next-state logic.
    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

    // A write to address 0 falls through the guard, so r0 never changes.
    logic writeHit;
    assign writeHit = regWrite && (write_reg != '0);

    // Next state: keep every register, except the one being written.
    always_comb begin
        regs_d = regs_q;
        if (writeHit) begin
            regs_d[write_reg] = writeData;
        end
        regs_d[0] = '0;
    end

    // Storage: the async reset clears everything and wins over a coincident edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Reads have no write-through bypass.
    // A same-cycle write becomes visible only after the edge.
    assign data1 = (reg1 == '0) ? '0 : regs_q[reg1];
    assign data2 = (reg2 == '0) ? '0 : regs_q[reg2];

endmodule

// File: tb/tb_register_file.sv
// tb_register_file: directed, self-checking bench for register_file.
// Each task drives one scenario and compares the read ports against
// hand-computed values.
module tb_register_file;

    logic        clk;
    logic        reset;
    logic [4:0]  reg1;
    logic [4:0]  reg2;
    logic [4:0]  write_reg;
    logic        regWrite;
    logic [31:0] writeData;
    logic [31:0] data1;
    logic [31:0] data2;

    int total;
    int bad;

    register_file dut (
        .clk       (clk),
        .reset     (reset),
        .reg1      (reg1),
        .reg2      (reg2),
        .write_reg (write_reg),
        .regWrite  (regWrite),
        .writeData (writeData),
        .data1     (data1),
        .data2     (data2)
    );

    // 10 ns clock period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hold reset for two edges while attempting a write.
    // Then sweep every address on both ports.
    task automatic test_reset();
        reset     = 1'b0;
        regWrite  = 1'b1;
        write_reg = 5'd9;
        writeData = 32'hA5A5A5A5;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 32; i++) begin
            reg1 = 5'(i);
            reg2 = 5'(31 - i);
            #1;
            total++;
            if (data1 !== 32'h0) begin
                bad++;
                $display("[TB] FAIL reset_data1 reg=%0d got=%h want=%h", i, data1, 32'h0);
            end
            total++;
            if (data2 !== 32'h0) begin
                bad++;
                $display("[TB] FAIL reset_data2 reg=%0d got=%h want=%h", 31 - i, data2, 32'h0);
            end
        end
        @(negedge clk);
        reset    = 1'b1;
        regWrite = 1'b0;
        reg1     = 5'd9;
        @(posedge clk);
        #1;
        total++;
        if (data1 !== 32'h0) begin
            bad++;
            $display("[TB] FAIL reset_write_ignored got=%h want=%h", data1, 32'h0);
        end
    endtask

    // Write r7 = 24.
    // The old value shows before the edge and the new one after it.
    task automatic test_basic_write();
        @(negedge clk);
        regWrite  = 1'b1;
        write_reg = 5'd7;
        writeData = 32'd24;
        reg1      = 5'd7;
        reg2      = 5'd7;
        #1;
        total++;
        if (data1 !== 32'h0) begin
            bad++;
            $display("[TB] FAIL basic_pre_edge got=%h want=%h", data1, 32'h0);
        end
        @(posedge clk);
        #1;
        total++;
        if (data1 !== 32'd24) begin
            bad++;
            $display("[TB] FAIL basic_data1 got=%h want=%h", data1, 32'd24);
        end
        total++;
        if (data2 !== 32'd24) begin
            bad++;
            $display("[TB] FAIL basic_data2 got=%h want=%h", data2, 32'd24);
        end
        @(negedge clk);
        regWrite = 1'b0;
    endtask

    // With regWrite low, an edge must leave r5 unchanged.
    task automatic test_write_disable();
        @(negedge clk);
        regWrite  = 1'b0;
        write_reg = 5'd5;
        writeData = 32'hDEADBEEF;
        reg1      = 5'd5;
        @(posedge clk);
        #1;
        total++;
        if (data1 !== 32'h0) begin
            bad++;
            $display("[TB] FAIL write_disable got=%h want=%h", data1, 32'h0);
        end
    endtask

    // A write to r0 must be discarded.
    task automatic test_r0_protect();
        @(negedge clk);
        regWrite  = 1'b1;
        write_reg = 5'd0;
        writeData = 32'hFFFFFFFF;
        reg1      = 5'd0;
        reg2      = 5'd0;
        @(posedge clk);
        #1;
        total++;
        if (data1 !== 32'h0) begin
            bad++;
            $display("[TB] FAIL r0_data1 got=%h want=%h", data1, 32'h0);
        end
        total++;
        if (data2 !== 32'h0) begin
            bad++;
            $display("[TB] FAIL r0_data2 got=%h want=%h", data2, 32'h0);
        end
        @(negedge clk);
        regWrite = 1'b0;
    endtask

    // Full-width values on both ports, then an overwrite of r3 timed around the edge.
    task automatic test_dual_read();
        @(negedge clk);
        regWrite  = 1'b1;
        write_reg = 5'd3;
        writeData = 32'h80000001;
        @(negedge clk);
        write_reg = 5'd31;
        writeData = 32'h7FFFFFFF;
        @(negedge clk);
        regWrite = 1'b0;
        reg1     = 5'd3;
        reg2     = 5'd31;
        #1;
        total++;
        if (data1 !== 32'h80000001) begin
            bad++;
            $display("[TB] FAIL dual_r3 got=%h want=%h", data1, 32'h80000001);
        end
        total++;
        if (data2 !== 32'h7FFFFFFF) begin
            bad++;
            $display("[TB] FAIL dual_r31 got=%h want=%h", data2, 32'h7FFFFFFF);
        end
        @(negedge clk);
        regWrite  = 1'b1;
        write_reg = 5'd3;
        writeData = 32'h12345678;
        #1;
        total++;
        if (data1 !== 32'h80000001) begin
            bad++;
            $display("[TB] FAIL overwrite_pre_edge got=%h want=%h", data1, 32'h80000001);
        end
        @(posedge clk);
        #1;
        total++;
        if (data1 !== 32'h12345678) begin
            bad++;
            $display("[TB] FAIL overwrite_post_edge got=%h want=%h", data1, 32'h12345678);
        end
        total++;
        if (data2 !== 32'h7FFFFFFF) begin
            bad++;
            $display("[TB] FAIL overwrite_r31_kept got=%h want=%h", data2, 32'h7FFFFFFF);
        end
        @(negedge clk);
        regWrite = 1'b0;
    endtask

    // Writes to r10, r11 and r12 on consecutive edges.
    // Then read them back, including one register on both ports.
    task automatic test_back_to_back();
        logic [31:0] vals [3];
        vals[0] = 32'h0000000A;
        vals[1] = 32'hCAFEF00D;
        vals[2] = 32'hFFFF0000;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            regWrite  = 1'b1;
            write_reg = 5'(10 + i);
            writeData = vals[i];
        end
        @(negedge clk);
        regWrite = 1'b0;
        for (int i = 0; i < 3; i++) begin
            reg1 = 5'(10 + i);
            reg2 = 5'(10 + i);
            #1;
            total++;
            if (data1 !== vals[i] || data2 !== vals[i]) begin
                bad++;
                $display("[TB] FAIL b2b_r%0d got=%h/%h want=%h", 10 + i, data1, data2, vals[i]);
            end
        end
    endtask

    // Pull reset low mid-period.
    // The reads must drop at once, and a write on the following edge must not land.
    task automatic test_async_reset();
        reg1 = 5'd7;
        reg2 = 5'd3;
        @(negedge clk);
        #1;
        total++;
        if (data1 !== 32'd24) begin
            bad++;
            $display("[TB] FAIL async_pre got=%h want=%h", data1, 32'd24);
        end
        #1;
        reset = 1'b0;
        #1;
        total++;
        if (data1 !== 32'h0) begin
            bad++;
            $display("[TB] FAIL async_data1 got=%h want=%h", data1, 32'h0);
        end
        total++;
        if (data2 !== 32'h0) begin
            bad++;
            $display("[TB] FAIL async_data2 got=%h want=%h", data2, 32'h0);
        end
        regWrite  = 1'b1;
        write_reg = 5'd7;
        writeData = 32'd55;
        @(posedge clk);
        #1;
        total++;
        if (data1 !== 32'h0) begin
            bad++;
            $display("[TB] FAIL async_write_blocked got=%h want=%h", data1, 32'h0);
        end
        @(negedge clk);
        reset    = 1'b1;
        regWrite = 1'b0;
        reg2     = 5'd31;
        @(posedge clk);
        #1;
        total++;
        if (data1 !== 32'h0 || data2 !== 32'h0) begin
            bad++;
            $display("[TB] FAIL async_cleared got=%h/%h want=%h", data1, data2, 32'h0);
        end
    endtask

    // Run every scenario in order, then report.
    initial begin
        total     = 0;
        bad       = 0;
        reset     = 1'b0;
        reg1      = '0;
        reg2      = '0;
        write_reg = '0;
        regWrite  = 1'b0;
        writeData = '0;
        test_reset();
        test_basic_write();
        test_write_disable();
        test_r0_protect();
        test_dual_read();
        test_back_to_back();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
